// File: rtl/ll_step_seq_if.sv
// ll_step_seq_if: bundles the step sequencer's request, memory, shared-adder
// and status signals.
//   slave  : sequencer side (ll_step_seq)
//   master : environment side (tick source, ll_memory, adder, display)
//   tick                  one-cycle step request
//   alt/vel/fuel/thrust   current state from ll_memory (BCD)
//   add_a/add_b/add_op    operands and op (0 add, 1 sub) to shared bcdaddsub4
//   add_s                 combinational result from bcdaddsub4
//   alt_n/vel_n/fuel_n    next values to ll_memory, valid while wen
//   wen                   one-cycle memory write pulse
//   busy/land/crash       status; land and crash are sticky
//   overrun               one-cycle pulse when a tick is dropped
interface ll_step_seq_if;
  logic        tick;
  logic [15:0] alt, vel, fuel, thrust;
  logic [15:0] add_s, add_a, add_b;
  logic        add_op;
  logic [15:0] alt_n, vel_n, fuel_n;
  logic        wen, busy, land, crash, overrun;

  modport slave (
    input  tick, alt, vel, fuel, thrust, add_s,
    output add_a, add_b, add_op, alt_n, vel_n, fuel_n,
           wen, busy, land, crash, overrun
  );

  modport master (
    output tick, alt, vel, fuel, thrust, add_s,
    input  add_a, add_b, add_op, alt_n, vel_n, fuel_n,
           wen, busy, land, crash, overrun
  );
endinterface

// File: rtl/ll_step_seq.sv
// ll_step_seq: runs one lunar-lander physics step through a single shared
// BCD add/subtract unit, one operation per clock:
//   ALT  alt + vel,  VEL1 vel - GRAVITY,  VEL2 t_vel + thr_eff,
//   FUEL fuel - thrust,  COMMIT clamp and write back (wen).
// Touching down (altitude <= 0) latches land, optionally crash, and parks
// in HALT until rst.
// Ports: clk, rst (async, active-high), bus (ll_step_seq_if.slave).
// Optional build macro LL_SEQ_AUTOTICK_EN: an internal TICK_DIV counter
// replaces the tick port as the step source.
module ll_step_seq #(
  parameter logic [15:0] GRAVITY   = 16'h0005,
  parameter logic [15:0] CRASH_VEL = 16'h9970,
  parameter int          TICK_DIV  = 100
) (
  input logic          clk,
  input logic          rst,
  ll_step_seq_if.slave bus
);

  typedef enum logic [2:0] {
    S_IDLE, S_ALT, S_VEL1, S_VEL2, S_FUEL, S_COMMIT, S_HALT
  } state_e;

  // 10's-complement BCD: MS digit 5..9 means negative
  function automatic logic is_neg(input logic [15:0] x);
    return x[15:12] >= 4'd5;
  endfunction

  state_e      state_q, state_d;
  logic [15:0] t_alt_q, t_alt_d, t_vel_q, t_vel_d, t_fuel_q, t_fuel_d;
  logic        pend_q, pend_d, land_q, land_d, crash_q, crash_d;
  logic        overrun_q, overrun_d;
  logic        tick_in, busy, alt_down;
  logic [15:0] thr_eff;

`ifdef LL_SEQ_AUTOTICK_EN
  localparam int CW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [CW-1:0] CNT_MAX = CW'(TICK_DIV - 1);
  logic [CW-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (state_q != S_HALT) cnt_d = (cnt_q == CNT_MAX) ? '0 : cnt_q + 1'b1;
  end

  always_ff @(posedge clk or posedge rst)
    if (rst) cnt_q <= '0;
    else     cnt_q <= cnt_d;

  assign tick_in = (cnt_q == CNT_MAX);
`else
  assign tick_in = bus.tick;
`endif

  assign busy     = (state_q != S_IDLE) && (state_q != S_HALT);
  assign thr_eff  = (bus.fuel == 16'h0000) ? 16'h0000 : bus.thrust;
  assign alt_down = is_neg(t_alt_q) || (t_alt_q == 16'h0000);

  always_comb begin
    state_d    = state_q;
    t_alt_d    = t_alt_q;
    t_vel_d    = t_vel_q;
    t_fuel_d   = t_fuel_q;
    pend_d     = pend_q;
    land_d     = land_q;
    crash_d    = crash_q;
    overrun_d  = 1'b0;
    bus.add_a  = 16'h0000;
    bus.add_b  = 16'h0000;
    bus.add_op = 1'b0;
    bus.wen    = 1'b0;
    bus.alt_n  = 16'h0000;
    bus.vel_n  = 16'h0000;
    bus.fuel_n = 16'h0000;

    // One tick may wait behind the running step; a second one is dropped.
    if (busy && tick_in) begin
      if (!pend_q) pend_d    = 1'b1;
      else         overrun_d = 1'b1;
    end

    case (state_q)
      S_IDLE: if (tick_in) state_d = S_ALT;
      S_ALT: begin
        bus.add_a = bus.alt;  bus.add_b = bus.vel;
        t_alt_d = bus.add_s;  state_d = S_VEL1;
      end
      S_VEL1: begin
        bus.add_a = bus.vel;  bus.add_b = GRAVITY;  bus.add_op = 1'b1;
        t_vel_d = bus.add_s;  state_d = S_VEL2;
      end
      S_VEL2: begin
        bus.add_a = t_vel_q;  bus.add_b = thr_eff;
        t_vel_d = bus.add_s;  state_d = S_FUEL;
      end
      S_FUEL: begin
        bus.add_a = bus.fuel; bus.add_b = bus.thrust; bus.add_op = 1'b1;
        t_fuel_d = bus.add_s; state_d = S_COMMIT;
      end
      S_COMMIT: begin
        bus.wen    = 1'b1;
        bus.alt_n  = alt_down ? 16'h0000 : t_alt_q;
        bus.vel_n  = alt_down ? 16'h0000 : t_vel_q;
        bus.fuel_n = ((bus.fuel == 16'h0000) || is_neg(t_fuel_q)) ? 16'h0000 : t_fuel_q;
        pend_d     = 1'b0;
        if (alt_down) begin
          land_d  = 1'b1;
          // plain unsigned compare is valid once vel is known negative
          crash_d = crash_q | (is_neg(bus.vel) && (bus.vel < CRASH_VEL));
          state_d = S_HALT;
        end else begin
          // a tick landing in COMMIT itself is consumed as the pending step
          state_d = (pend_q || tick_in) ? S_ALT : S_IDLE;
        end
      end
      S_HALT:  state_d = S_HALT;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= S_IDLE;
      t_alt_q   <= 16'h0000;
      t_vel_q   <= 16'h0000;
      t_fuel_q  <= 16'h0000;
      pend_q    <= 1'b0;
      land_q    <= 1'b0;
      crash_q   <= 1'b0;
      overrun_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      t_alt_q   <= t_alt_d;
      t_vel_q   <= t_vel_d;
      t_fuel_q  <= t_fuel_d;
      pend_q    <= pend_d;
      land_q    <= land_d;
      crash_q   <= crash_d;
      overrun_q <= overrun_d;
    end
  end

  assign bus.busy    = busy;
  assign bus.land    = land_q;
  assign bus.crash   = crash_q;
  assign bus.overrun = overrun_q;

endmodule

// File: tb/tb_ll_step_seq.sv
// tb_ll_step_seq: table-driven and randomized checks of ll_step_seq with a
// behavioural 4-digit BCD add/sub standing in for the external bcdaddsub4.
module tb_ll_step_seq;
  logic clk, rst;
  ll_step_seq_if bus();

  ll_step_seq dut (.clk(clk), .rst(rst), .bus(bus));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic int b2i(input logic [15:0] b);
    return int'(b[15:12]) * 1000 + int'(b[11:8]) * 100 + int'(b[7:4]) * 10 + int'(b[3:0]);
  endfunction

  function automatic logic [15:0] i2b(input int v);
    return {4'((v / 1000) % 10), 4'((v / 100) % 10), 4'((v / 10) % 10), 4'(v % 10)};
  endfunction

  // external shared adder: 10's-complement BCD mod 10000
  always_comb
    bus.add_s = i2b(bus.add_op ? (b2i(bus.add_a) + 10000 - b2i(bus.add_b)) % 10000
                               : (b2i(bus.add_a) + b2i(bus.add_b)) % 10000);

  typedef struct {
    logic [15:0] alt, vel, fuel, thr;
    logic [15:0] ea, ev, ef;
    logic        el, ec;
  } vec_t;

  // decimal physics: gravity 5, thrust only with fuel, clamp at surface
  function automatic vec_t ref_step(input vec_t x);
    vec_t r = x;
    int ai = b2i(x.alt), vi = b2i(x.vel), fi = b2i(x.fuel), ti = b2i(x.thr);
    int nalt  = (ai + vi) % 10000;
    int nvel  = (vi + 10000 - 5 + ((fi == 0) ? 0 : ti)) % 10000;
    int nfuel = (fi + 10000 - ti) % 10000;
    bit down  = (nalt == 0) || (nalt >= 5000);
    r.ea = down ? 16'h0 : i2b(nalt);
    r.ev = down ? 16'h0 : i2b(nvel);
    r.ef = (fi == 0 || nfuel >= 5000) ? 16'h0 : i2b(nfuel);
    r.el = down;
    r.ec = down && vi >= 5000 && vi < 9970;
    return r;
  endfunction

  int checks = 0, failures = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic do_reset();
    rst = 1'b1; bus.tick = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic set_in(input vec_t v);
    bus.alt = v.alt; bus.vel = v.vel; bus.fuel = v.fuel; bus.thrust = v.thr;
  endtask

  // issue one tick at a negedge, wait (bounded) for wen, capture outputs,
  // then one more cycle for the sticky flags
  task automatic run_step(input vec_t v, output vec_t g, output int lat);
    g = v;
    set_in(v);
    bus.tick = 1'b1; lat = 0;
    @(negedge clk); bus.tick = 1'b0; lat = 1;
    while (!bus.wen && lat < 20) begin @(negedge clk); lat++; end
    g.ea = bus.alt_n; g.ev = bus.vel_n; g.ef = bus.fuel_n;
    @(negedge clk);
    g.el = bus.land; g.ec = bus.crash;
  endtask

  task automatic cmp_step(input string nm, input vec_t e, input vec_t g, input int lat);
    chk({nm, "_lat"},   lat,  5);
    chk({nm, "_alt"},   g.ea, e.ea);
    chk({nm, "_vel"},   g.ev, e.ev);
    chk({nm, "_fuel"},  g.ef, e.ef);
    chk({nm, "_land"},  g.el, e.el);
    chk({nm, "_crash"}, g.ec, e.ec);
  endtask

  vec_t tbl[9];

  initial begin
    vec_t g, nom;
    int lat, nw, no, wpos0, wpos1;
    logic [3:0] ops;

    tbl[0] = '{16'h4500, 16'h0000, 16'h0800, 16'h0005, 16'h4500, 16'h0000, 16'h0795, 1'b0, 1'b0};
    tbl[1] = '{16'h1000, 16'h0000, 16'h0000, 16'h0005, 16'h1000, 16'h9995, 16'h0000, 1'b0, 1'b0};
    tbl[2] = '{16'h0010, 16'h9980, 16'h0100, 16'h0000, 16'h0000, 16'h0000, 16'h0100, 1'b1, 1'b0};
    tbl[3] = '{16'h0010, 16'h9950, 16'h0100, 16'h0000, 16'h0000, 16'h0000, 16'h0100, 1'b1, 1'b1};
    tbl[4] = '{16'h0010, 16'h9970, 16'h0100, 16'h0000, 16'h0000, 16'h0000, 16'h0100, 1'b1, 1'b0};
    tbl[5] = '{16'h2000, 16'h0000, 16'h0003, 16'h0005, 16'h2000, 16'h0000, 16'h0000, 1'b0, 1'b0};
    tbl[6] = '{16'h0030, 16'h9970, 16'h0100, 16'h0000, 16'h0000, 16'h0000, 16'h0100, 1'b1, 1'b0};
    tbl[7] = '{16'h1234, 16'h0100, 16'h0500, 16'h0010, 16'h1334, 16'h0105, 16'h0490, 1'b0, 1'b0};
    tbl[8] = '{16'h0005, 16'h9900, 16'h0050, 16'h0020, 16'h0000, 16'h0000, 16'h0030, 1'b1, 1'b1};
    nom = tbl[0];

    rst = 1'b1; bus.tick = 1'b0; set_in(nom);
    do_reset();
    chk("rst_wen", bus.wen, 0);   chk("rst_busy", bus.busy, 0);
    chk("rst_land", bus.land, 0); chk("rst_crash", bus.crash, 0);
    chk("rst_ovr", bus.overrun, 0);
    chk("rst_outs", {bus.alt_n, bus.vel_n}, 0); chk("rst_fuel_n", bus.fuel_n, 0);
    chk("rst_adder", {bus.add_a, bus.add_b}, 0); chk("rst_op", bus.add_op, 0);

    // table vectors
    for (int i = 0; i < 9; i++) begin
      do_reset();
      run_step(tbl[i], g, lat);
      cmp_step($sformatf("tbl%0d", i), tbl[i], g, lat);
    end

    // nominal: busy window and adder op sequence
    do_reset(); set_in(nom);
    bus.tick = 1'b1; ops = '0;
    for (int c = 1; c <= 6; c++) begin
      @(negedge clk); bus.tick = 1'b0;
      if (c <= 4) ops[c-1] = bus.add_op;
      if (c == 1) chk("nom_add_a_alt", bus.add_a, 16'h4500);
      if (c == 5) chk("nom_wen", bus.wen, 1);
      chk($sformatf("nom_busy_c%0d", c), bus.busy, (c <= 5) ? 1 : 0);
    end
    chk("nom_ops", ops, 4'b1010);
    chk("nom_adder_idle", {bus.add_a, bus.add_b, 15'd0, bus.add_op}, 0);

    // halt: further ticks ignored after a soft landing
    do_reset();
    run_step(tbl[2], g, lat);
    nw = 0; no = 0;
    bus.tick = 1'b1;
    for (int c = 0; c < 8; c++) begin
      @(negedge clk);
      nw += int'(bus.wen); no += int'(bus.overrun);
    end
    bus.tick = 1'b0;
    chk("halt_wen", nw, 0); chk("halt_ovr", no, 0);
    chk("halt_busy", bus.busy, 0); chk("halt_land", bus.land, 1);

    // overrun: ticks at cycles 0,1,2 -> pend, drop, back-to-back steps
    do_reset(); set_in(nom);
    nw = 0; wpos0 = -1; wpos1 = -1;
    bus.tick = 1'b1;
    for (int c = 1; c <= 14; c++) begin
      @(negedge clk);
      if (c == 3) bus.tick = 1'b0;
      if (c == 2) chk("ovr_c2", bus.overrun, 0);
      if (c == 3) chk("ovr_c3", bus.overrun, 1);
      if (c == 4) chk("ovr_c4", bus.overrun, 0);
      if (bus.wen) begin
        if (nw == 0) wpos0 = c; else wpos1 = c;
        nw++;
      end
    end
    chk("ovr_wen_cnt", nw, 2);
    chk("ovr_wen0", wpos0, 5);
    chk("ovr_wen1", wpos1, 10);

    // reset during VEL2 aborts the step
    do_reset(); set_in(nom);
    bus.tick = 1'b1;
    @(negedge clk); bus.tick = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b1; #1;
    chk("abort_busy", bus.busy, 0); chk("abort_wen", bus.wen, 0);
    chk("abort_outs", {bus.alt_n, bus.vel_n}, 0); chk("abort_fuel_n", bus.fuel_n, 0);
    chk("abort_flags", {bus.land, bus.crash, bus.overrun}, 0);
    nw = 0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    for (int c = 0; c < 8; c++) begin @(negedge clk); nw += int'(bus.wen); end
    chk("abort_no_wen", nw, 0);

    // randomized steps against the decimal model
    for (int i = 0; i < 30; i++) begin
      vec_t v;
      v.alt  = i2b(($urandom_range(0, 3) == 0) ? $urandom_range(0, 60) : $urandom_range(0, 4999));
      v.vel  = i2b(($urandom_range(0, 1) == 0) ? $urandom_range(0, 200) : $urandom_range(9850, 9999));
      v.fuel = i2b(($urandom_range(0, 4) == 0) ? 0 : $urandom_range(0, 999));
      v.thr  = i2b($urandom_range(0, 30));
      v.ea = 0; v.ev = 0; v.ef = 0; v.el = 0; v.ec = 0;
      do_reset();
      run_step(v, g, lat);
      cmp_step($sformatf("rnd%0d", i), ref_step(v), g, lat);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/ll_step_seq.md
Name: ll_step_seq

Overview:
Sequences one lunar-lander physics step through a single shared 16-bit BCD add/subtract unit (an external bcdaddsub4), one operation per clock. The datapath has no per-quantity adder array. The block sits between the tick source, ll_memory (drives wen, alt_n, vel_n, fuel_n) and the display/LED logic (land, crash, busy). It performs clamping, landing detection and crash detection, then halts the lander until reset.

Parameters:
GRAVITY, 16'h0005, BCD gravity subtracted from velocity each step
CRASH_VEL, 16'h9970, 10's-complement BCD velocity limit (-30); touchdown with vel below this is a crash
TICK_DIV, 100, clocks per internal tick; used only with LL_SEQ_AUTOTICK_EN

Ports:
clk  in  1  system clock
rst  in  1  asynchronous active-high reset
tick  in  1  one-cycle step request
alt  in  16  current altitude (BCD, from ll_memory)
vel  in  16  current velocity (BCD 10's complement)
fuel  in  16  current fuel (BCD)
thrust  in  16  current thrust (BCD)
add_s  in  16  result from shared bcdaddsub4 (combinational)
add_a  out  16  shared adder operand A
add_b  out  16  shared adder operand B
add_op  out  1  shared adder op (0 add, 1 subtract)
alt_n  out  16  next altitude to ll_memory
vel_n  out  16  next velocity to ll_memory
fuel_n  out  16  next fuel to ll_memory
wen  out  1  ll_memory write enable, one-cycle pulse
busy  out  1  step in progress
land  out  1  sticky: lander on surface
crash  out  1  sticky: landing exceeded CRASH_VEL
overrun  out  1  one-cycle pulse: tick dropped

Behaviour:
- Clock and reset: one clock, clk. rst is asynchronous and active-high. On rst: state IDLE; temps t_alt, t_vel, t_fuel, pend, land, crash, overrun = 0. Outputs wen=0, busy=0, alt_n/vel_n/fuel_n=0.
- Negative value rule: a BCD word is negative when its MS digit >= 5.
- States: IDLE, ALT, VEL1, VEL2, FUEL, COMMIT, HALT.
- IDLE: tick=1 -> ALT. Otherwise stay.
- ALT: operation alt+vel (op=0); t_alt <= add_s.
- VEL1: operation vel-GRAVITY (op=1); t_vel <= add_s.
- VEL2: operation t_vel+thr_eff (op=0); t_vel <= add_s. thr_eff = 0 when fuel==0, else thrust.
- FUEL: operation fuel-thrust (op=1); t_fuel <= add_s.
- COMMIT: wen=1 for exactly this cycle. Memory latches on the edge leaving COMMIT.
- In ALT/VEL1/VEL2/FUEL, add_a/add_b/add_op are decoded from state. In IDLE/COMMIT/HALT they are 0/0/0.
- Latency: the edge that samples tick enters ALT. COMMIT is entered 4 edges later. The new values are in ll_memory 5 edges after sampling.
- Output clamping, valid while wen=1:
  - If t_alt negative or zero: alt_n=0, vel_n=0.
  - Otherwise: alt_n=t_alt, vel_n=t_vel.
  - fuel_n=0 if fuel==0 or t_fuel negative; else fuel_n=t_fuel.
- Landing (t_alt negative or zero in COMMIT):
  - On the edge leaving COMMIT: land<=1, next state HALT.
  - crash<=1 if input vel is negative and vel < CRASH_VEL (unsigned compare). vel == CRASH_VEL is safe.
- Otherwise, leaving COMMIT: next state ALT if pend, else IDLE; pend cleared.
- busy = 1 in ALT..COMMIT, 0 in IDLE/HALT.
- Tick while busy: if pend=0, set pend. If pend=1, drop the tick and pulse overrun for one cycle.
- Tick in COMMIT counts as while-busy.
- HALT: ticks ignored, no overrun. Only rst exits.
- Inputs alt/vel/fuel/thrust are stable ALT..FUEL because memory writes only at wen.
- rst mid-step aborts the step immediately; no wen is issued.

Optional Feature:
LL_SEQ_AUTOTICK_EN
- Defined: an internal counter 0..TICK_DIV-1 generates the tick on wrap. The tick port is ignored. The counter is reset by rst and frozen in HALT.
- Undefined: no counter; the tick port is the only step source.

Test Plan:
- Nominal step: alt=4500, vel=0000, fuel=0800, thrust=0005, tick -> wen pulse 4 edges later; alt_n=4500, vel_n=0000, fuel_n=0795; busy high 5 cycles; add_op sequence 0,1,0,1.
- Empty tank: alt=1000, vel=0000, fuel=0000, thrust=0005 -> vel_n=9995, fuel_n=0000, alt_n=1000.
- Soft landing: alt=0010, vel=9980, fuel=0100, thrust=0000 -> alt_n=0000, vel_n=0000, land=1, crash=0, state HALT; further ticks give no wen and no overrun.
- Crash landing: alt=0010, vel=9950 -> land=1, crash=1. Boundary case: vel=9970 -> crash=0.
- Fuel underflow: fuel=0003, thrust=0005, alt=2000 -> fuel_n=0000.
- Overrun and reset: tick at cycle 0, 1 and 2 -> pend set at cycle 1, overrun pulse at cycle 2, back-to-back second step (two wen pulses 5 cycles apart). Then rst asserted during VEL2 -> no wen; all outputs 0.
